// File: rtl/alu_issue_stage_pkg.sv
// Shared ISA definitions for the issue stage and the ALU: default widths, opcode values,
// instruction field layout, and a helper that classifies opcodes.
// Latency: n/a (types and constants only). Backpressure: n/a.
package alu_issue_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREG   = 32;
  localparam int DEF_REG_AW = 5;
  localparam int INST_W     = 32;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd3;
  localparam logic [4:0] OP_SUB = 5'd4;
  localparam logic [4:0] OP_MUL = 5'd5;
  localparam logic [4:0] OP_DIV = 5'd6;
  localparam logic [4:0] OP_AND = 5'd7;

  // Instruction word: [31:27] opcode, [26:22] rd, [21:17] rs1, [16:12] rs2, [11:0] unused
  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] unused;
  } inst_t;

  // True for opcodes that occupy the ALU issue slot
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
           (op == OP_DIV) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/alu_issue_stage_regfile_2r1w.sv
// Register file with two async read ports and one sync write port; r0 always reads 0.
// Latency: reads combinational, write visible the cycle after the write edge.
// Backpressure: none, always accepts a write.
// Ports: clk, rst_n, ra1/rd1, ra2/rd2 (read ports), we/wa/wd (write port).
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    // r0 is hardwired; its storage is never written
    if (we && (wa != '0)) begin
      mem_d[wa] = wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem_q[ra2];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/operand-issue stage: reads rs1/rs2 with write-back bypass, blocks on scoreboard hazards.
// Latency: 1 cycle from accept to out_valid; illegal pulses 1 cycle after accept.
// Backpressure: in_ready drops while the slot is held (out_valid & !out_ready) or on a hazard.
// Ports: in_valid/in_ready/in_inst (instruction in), out_valid/out_ready/operand_a/operand_b/
//        op_code/out_rd (ALU slot), wb_valid/wb_rd/wb_data (write-back), illegal (pulse).
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [INST_W-1:0] op_code,
  output logic [REG_AW-1:0] out_rd,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              illegal
);

  inst_t inst;
  assign inst = inst_t'(in_inst);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] operand_a_q, operand_a_d;
  logic [DATA_W-1:0] operand_b_q, operand_b_d;
  logic [INST_W-1:0] op_code_q, op_code_d;
  logic [REG_AW-1:0] out_rd_q, out_rd_d;
  logic              illegal_q, illegal_d;
  logic [NREG-1:0]   pend_q, pend_d;

  logic [NREG-1:0]   wb_clr;
  logic [NREG-1:0]   pend_eff;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic [DATA_W-1:0] op_a, op_b;
  logic              hazard, slot_free, accept, alu_op, bad_op;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (inst.rs1),
    .rd1   (rf_rd1),
    .ra2   (inst.rs2),
    .rd2   (rf_rd2),
    .we    (wb_valid),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  // A register being written back this cycle is already resolved for hazard purposes
  always_comb begin
    wb_clr = '0;
    if (wb_valid && (wb_rd != '0)) begin
      wb_clr[wb_rd] = 1'b1;
    end
  end

  assign pend_eff  = pend_q & ~wb_clr;
  assign hazard    = pend_eff[inst.rs1] | pend_eff[inst.rs2] | pend_eff[inst.rd];
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = slot_free && !hazard;
  assign accept    = in_valid && in_ready;
  assign alu_op    = is_alu_op(inst.opcode);
  assign bad_op    = !alu_op && (inst.opcode != OP_NOP);

  // Bypass the write-back value so a dependent op can issue in the wb cycle itself
  always_comb begin
    op_a = rf_rd1;
    if (wb_valid && (wb_rd == inst.rs1)) begin
      op_a = wb_data;
    end
    if (inst.rs1 == '0) begin
      op_a = '0;
    end
    op_b = rf_rd2;
    if (wb_valid && (wb_rd == inst.rs2)) begin
      op_b = wb_data;
    end
    if (inst.rs2 == '0) begin
      op_b = '0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    op_code_d   = op_code_q;
    out_rd_d    = out_rd_q;
    illegal_d   = accept && bad_op;
    pend_d      = pend_eff;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && alu_op) begin
      out_valid_d = 1'b1;
      operand_a_d = op_a;
      operand_b_d = op_b;
      op_code_d   = in_inst;
      out_rd_d    = inst.rd;
      // Applied after the wb clear so a same-cycle set on the same rd wins
      if (inst.rd != '0) begin
        pend_d[inst.rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      operand_a_q <= '0;
      operand_b_q <= '0;
      op_code_q   <= '0;
      out_rd_q    <= '0;
      illegal_q   <= 1'b0;
      pend_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      op_code_q   <= op_code_d;
      out_rd_q    <= out_rd_d;
      illegal_q   <= illegal_d;
      pend_q      <= pend_d;
    end
  end

  assign out_valid = out_valid_q;
  assign operand_a = operand_a_q;
  assign operand_b = operand_b_q;
  assign op_code   = op_code_q;
  assign out_rd    = out_rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: hand-computed vectors for issue, hazards, bypass,
// backpressure, illegal opcodes, r0 handling and asynchronous reset.
// Inputs change 1 ns after the rising edge; outputs are sampled away from the edge.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] op_code;
  logic [4:0]  out_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  alu_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .op_code   (op_code),
    .out_rd    (out_rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 12'h000};
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    out_ready = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;

    cyc();
    cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_illegal",   {31'd0, illegal},   32'd0);
    chk("rst_operand_a", operand_a, 32'd0);
    chk("rst_operand_b", operand_b, 32'd0);
    chk("rst_op_code",   op_code,   32'd0);
    chk("rst_out_rd",    {27'd0, out_rd}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // 1: preload r28=5, r10=8, then ADD rd28,rs28,rs10
    wb_valid = 1'b1; wb_rd = 5'd28; wb_data = 32'd5;
    cyc();
    wb_rd = 5'd10; wb_data = 32'd8;
    cyc();
    wb_valid  = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h1F38A000;
    #1 chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_operand_a", operand_a, 32'd5);
    chk("t1_operand_b", operand_b, 32'd8);
    chk("t1_op_code",   op_code,   32'h1F38A000);
    chk("t1_out_rd",    {27'd0, out_rd}, 32'd28);
    // r28 now pending: a reader of r28 must stall
    in_inst = mk(5'd4, 5'd9, 5'd28, 5'd0);
    #1 chk("t1_raw_r28", {31'd0, in_ready}, 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd28; wb_data = 32'd5;
    cyc();
    wb_valid = 1'b0;
    chk("t1_drained", {31'd0, out_valid}, 32'd0);

    // 2: RAW stall on r3 released by write-back with bypass
    in_valid = 1'b1;
    in_inst  = mk(5'd3, 5'd3, 5'd1, 5'd2);
    cyc();
    in_inst = mk(5'd4, 5'd4, 5'd3, 5'd10);
    #1 chk("t2_stall0", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("t2_stall1", {31'd0, in_ready}, 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd13;
    #1 chk("t2_wb_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    wb_valid = 1'b0;
    in_valid = 1'b0;
    chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_bypass_a",  operand_a, 32'd13);
    chk("t2_operand_b", operand_b, 32'd8);
    chk("t2_out_rd",    {27'd0, out_rd}, 32'd4);

    // 3: backpressure holds the SUB; queued AND issues after drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = mk(5'd7, 5'd5, 5'd10, 5'd28);
    #1 chk("t3_ready_held", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_hold_a",     operand_a, 32'd13);
    chk("t3_hold_rd",    {27'd0, out_rd}, 32'd4);
    cyc();
    chk("t3_hold_op",    op_code, mk(5'd4, 5'd4, 5'd3, 5'd10));
    chk("t3_hold_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1 chk("t3_ready_drain", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("t3_next_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_next_rd",    {27'd0, out_rd}, 32'd5);
    chk("t3_next_a",     operand_a, 32'd8);
    chk("t3_next_b",     operand_b, 32'd5);
    chk("t3_next_op",    op_code, mk(5'd7, 5'd5, 5'd10, 5'd28));

    // clear r4/r5 pending via write-back, values checked on readback below
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    cyc();
    wb_rd = 5'd5; wb_data = 32'h55;
    cyc();
    wb_valid = 1'b0;

    // 4: illegal opcode 0x1F consumed, pulses illegal, never loads slot
    in_valid = 1'b1;
    in_inst  = 32'hF8000000;
    #1 chk("t4_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("t4_illegal_hi", {31'd0, illegal},   32'd1);
    chk("t4_no_valid",   {31'd0, out_valid}, 32'd0);
    cyc();
    chk("t4_illegal_lo", {31'd0, illegal},   32'd0);
    in_valid = 1'b1;
    in_inst  = mk(5'd3, 5'd6, 5'd4, 5'd5);
    #1 chk("t4_sb_clean", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("t4_rf_r4", operand_a, 32'h44);
    chk("t4_rf_r5", operand_b, 32'h55);

    // 5: r0 reads zero, never pending, ignores writes and bypass
    in_inst = mk(5'd3, 5'd0, 5'd0, 5'd0);
    cyc();
    chk("t5_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_a0",    operand_a, 32'd0);
    chk("t5_b0",    operand_b, 32'd0);
    chk("t5_rd0",   {27'd0, out_rd}, 32'd0);
    #1 chk("t5_no_pend0", {31'd0, in_ready}, 32'd1);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    cyc();
    wb_valid = 1'b0;
    chk("t5_wb_bypass0", operand_a, 32'd0);
    cyc();
    chk("t5_after_wb0", operand_b, 32'd0);

    // NOP drains the slot without loading it
    in_inst = 32'h00000000;
    cyc();
    in_valid = 1'b0;
    chk("nop_no_valid", {31'd0, out_valid}, 32'd0);
    chk("nop_no_illegal", {31'd0, illegal}, 32'd0);

    // 6: async reset while slot full and r5 pending
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = mk(5'd3, 5'd5, 5'd1, 5'd2);
    cyc();
    in_valid = 1'b0;
    chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1 chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = mk(5'd3, 5'd1, 5'd5, 5'd5);
    #1 chk("t6_ready_after", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("t6_issue_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_rf_cleared",  operand_a, 32'd0);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
